// File: rtl/rca_pkg.sv
// Shared definitions for the ripple-carry accumulator: FSM encoding and per-set result width.
package rca_pkg;

    localparam int unsigned RES_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_e;

endpackage

// File: rtl/rca.sv
// 4-bit ripple-carry adder: {cout,sum} = a + b + cin.
module rca (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic c1, c2, c3;

    assign c1   = (a[0] & b[0]) | (cin & (a[0] ^ b[0]));
    assign c2   = (a[1] & b[1]) | (c1  & (a[1] ^ b[1]));
    assign c3   = (a[2] & b[2]) | (c2  & (a[2] ^ b[2]));
    assign cout = (a[3] & b[3]) | (c3  & (a[3] ^ b[3]));
    assign sum  = a ^ b ^ {c3, c2, c1, cin};

endmodule

// File: rtl/rca_accum.sv
// Sums N_OPS accepted rca results into an ACC_W-bit accumulator with a sticky overflow flag,
// then holds the total until the downstream consumer takes it.
module rca_accum
    import rca_pkg::*;
#(
    parameter int unsigned N_OPS = 4,
    parameter int unsigned ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic             out_ovf
);

    logic [3:0]       sum4;
    logic             cout;
    logic [RES_W-1:0] res;
    logic [ACC_W-1:0] res_ext;
    logic [ACC_W:0]   acc_sum;
    logic             accept;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    // Holds in_ready low until the first edge after reset release.
    logic             live_q;

    rca u_rca (
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sum  (sum4),
        .cout (cout)
    );

    assign res     = {cout, sum4};
    assign res_ext = {{(ACC_W - RES_W){1'b0}}, res};
    assign acc_sum = {1'b0, acc_q} + {1'b0, res_ext};

    assign in_ready  = live_q && (state_q != DONE);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign out_total = acc_q;
    assign out_ovf   = ovf_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = res_ext;
                    cnt_d   = 4'd1;
                    state_d = (N_OPS == 1) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d = acc_sum[ACC_W-1:0];
                    cnt_d = cnt_q + 4'd1;
                    ovf_d = ovf_q | acc_sum[ACC_W];
                    if (cnt_d == 4'(N_OPS)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                acc_d   = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
            end
        endcase
        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            live_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rca_accum.sv
// Self-checking bench for rca_accum: three instances (N_OPS=4/15/1) checked against
// table vectors, hand sequences and a sum-of-results reference model.
module tb_rca_accum;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] a = 4'd0;
    logic [3:0] b = 4'd0;
    logic       cin = 1'b0;
    logic [2:0] iv = 3'b000;

    logic [2:0] ir;
    logic [2:0] ov;
    logic [2:0] of;
    logic [7:0] tot0;
    logic [7:0] tot1;
    logic [4:0] tot2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rca_accum #(.N_OPS(4), .ACC_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a), .b(b), .cin(cin), .out_valid(ov[0]), .out_ready(out_ready),
        .out_total(tot0), .out_ovf(of[0])
    );

    rca_accum #(.N_OPS(15), .ACC_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a), .b(b), .cin(cin), .out_valid(ov[1]), .out_ready(out_ready),
        .out_total(tot1), .out_ovf(of[1])
    );

    rca_accum #(.N_OPS(1), .ACC_W(5)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a), .b(b), .cin(cin), .out_valid(ov[2]), .out_ready(out_ready),
        .out_total(tot2), .out_ovf(of[2])
    );

    typedef struct {
        logic [3:0] va;
        logic [3:0] vb;
        logic       vc;
        int         exp_total;
        int         exp_valid;
    } vec_t;

    vec_t tbl[4];

    function automatic int tot(input int d);
        case (d)
            0:       return int'(tot0);
            1:       return int'(tot1);
            default: return int'(tot2);
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Presents one operand set for a single edge; returns at the following negedge.
    task automatic accept(input int d, input logic [3:0] aa, input logic [3:0] bb,
                          input logic cc);
        check("accept_ready", int'(ir[d]), 1);
        a = aa;
        b = bb;
        cin = cc;
        iv[d] = 1'b1;
        @(negedge clk);
        iv[d] = 1'b0;
    endtask

    task automatic consume(input int d);
        check("consume_valid", int'(ov[d]), 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("consume_idle_valid", int'(ov[d]), 0);
        check("consume_idle_ready", int'(ir[d]), 1);
        check("consume_idle_total", tot(d), 0);
        check("consume_idle_ovf", int'(of[d]), 0);
    endtask

    initial begin
        int d;
        int n;
        int sum;
        logic [3:0] ra;
        logic [3:0] rb;
        logic       rc;

        tbl[0] = '{4'd3,  4'd4,  1'b0, 7,  0};
        tbl[1] = '{4'd15, 4'd15, 1'b1, 38, 0};
        tbl[2] = '{4'd0,  4'd0,  1'b0, 38, 0};
        tbl[3] = '{4'd1,  4'd2,  1'b1, 42, 1};

        // Reset state
        #1;
        check("rst_valid", int'(ov[0]), 0);
        check("rst_total", tot(0), 0);
        check("rst_ovf", int'(of[0]), 0);
        check("rst_ready", int'(ir[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_release_ready", int'(ir[0]), 0);
        @(negedge clk);
        check("first_edge_ready", int'(ir[0]), 1);

        // Basic table run, N_OPS=4
        for (int i = 0; i < 4; i++) begin
            accept(0, tbl[i].va, tbl[i].vb, tbl[i].vc);
            check("tbl_total", tot(0), tbl[i].exp_total);
            check("tbl_valid", int'(ov[0]), tbl[i].exp_valid);
        end
        check("tbl_ovf", int'(of[0]), 0);

        // Backpressure in DONE with in_valid held high
        out_ready = 1'b0;
        a = 4'd9;
        b = 4'd9;
        iv[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_ready", int'(ir[0]), 0);
            @(negedge clk);
            check("bp_total", tot(0), 42);
            check("bp_valid", int'(ov[0]), 1);
        end
        iv[0] = 1'b0;
        consume(0);

        // Clear after two accepts, with a simultaneous accept that must be dropped
        accept(0, 4'd5, 4'd5, 1'b0);
        accept(0, 4'd5, 4'd5, 1'b0);
        check("pre_clear_total", tot(0), 20);
        clear = 1'b1;
        iv[0] = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        iv[0] = 1'b0;
        check("clear_total", tot(0), 0);
        check("clear_valid", int'(ov[0]), 0);
        check("clear_ready", int'(ir[0]), 1);
        for (int i = 0; i < 4; i++) accept(0, 4'd1, 4'd0, 1'b0);
        check("post_clear_total", tot(0), 4);
        check("post_clear_ovf", int'(of[0]), 0);
        consume(0);

        // N_OPS=15 overflow
        for (int i = 0; i < 15; i++) begin
            accept(1, 4'd15, 4'd15, 1'b1);
            check("ovf15_valid", int'(ov[1]), (i == 14) ? 1 : 0);
        end
        check("ovf15_total", tot(1), 209);
        check("ovf15_ovf", int'(of[1]), 1);
        consume(1);

        // N_OPS=1, ACC_W=5: single accept goes straight to DONE
        accept(2, 4'd15, 4'd15, 1'b1);
        check("n1_valid", int'(ov[2]), 1);
        check("n1_total", tot(2), 31);
        check("n1_ovf", int'(of[2]), 0);
        consume(2);

        // Asynchronous reset while in DONE
        for (int i = 0; i < 4; i++) accept(0, tbl[i].va, tbl[i].vb, tbl[i].vc);
        check("pre_rst_valid", int'(ov[0]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", int'(ov[0]), 0);
        check("async_rst_total", tot(0), 0);
        check("async_rst_ready", int'(ir[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Same vectors with 3-cycle gaps
        for (int i = 0; i < 4; i++) begin
            accept(0, tbl[i].va, tbl[i].vb, tbl[i].vc);
            if (i < 3) begin
                a = 4'd15;
                b = 4'd15;
                repeat (3) @(negedge clk);
                check("gap_total", tot(0), tbl[i].exp_total);
                check("gap_valid", int'(ov[0]), 0);
            end
        end
        check("gap_final_total", tot(0), 42);
        check("gap_final_valid", int'(ov[0]), 1);
        consume(0);

        // Randomised runs against a sum-of-results model
        for (int it = 0; it < 24; it++) begin
            d = it % 2;
            n = (d == 1) ? 15 : 4;
            sum = 0;
            for (int k = 0; k < n; k++) begin
                ra = 4'($urandom_range(15, 0));
                rb = 4'($urandom_range(15, 0));
                rc = 1'($urandom_range(1, 0));
                sum += int'(ra) + int'(rb) + int'(rc);
                accept(d, ra, rb, rc);
                if (k < n - 1) begin
                    check("rnd_mid_valid", int'(ov[d]), 0);
                    repeat ($urandom_range(2, 0)) @(negedge clk);
                end
            end
            check("rnd_valid", int'(ov[d]), 1);
            check("rnd_total", tot(d), sum % 256);
            check("rnd_ovf", int'(of[d]), (sum > 255) ? 1 : 0);
            repeat ($urandom_range(3, 0)) @(negedge clk);
            check("rnd_hold_total", tot(d), sum % 256);
            consume(d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
